// File: rtl/pc_gen_d_if.sv
// rtl/pc_gen_d_if.sv - fetch-side bundle between the PC generator and the fetch stage, BTB and backend
interface pc_gen_d_if;
    logic        stall;
    logic        branch_flush;
    logic [31:0] branch_target;
    logic [1:0]  btb_valid;
    logic [31:0] pre_branch_addr [2];
    logic [31:0] pc [2];
    logic        inst_en;
    logic [1:0]  pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pred_pc;
    logic        kill_slot1;

    modport master (
        input  stall, branch_flush, branch_target, btb_valid, pre_branch_addr,
        output pc, inst_en, pred_taken, pred_target, pred_pc, kill_slot1
    );

    modport slave (
        output stall, branch_flush, branch_target, btb_valid, pre_branch_addr,
        input  pc, inst_en, pred_taken, pred_target, pred_pc, kill_slot1
    );
endinterface

// File: rtl/pc_gen_d.sv
// rtl/pc_gen_d.sv - dual-slot fetch PC generator; BTB redirect enabled by macro BTB_PREDICT_EN
module pc_gen_d #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rst,
    pc_gen_d_if.master  bus
);

    typedef enum logic {BOOT, RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] p_q, p_d;
    logic [31:0] pc_q, pc_d;
    logic        iss_q, iss_d;

    logic        hit;
    logic [1:0]  taken;
    logic [31:0] target_pred;
    logic        inst_en;
    logic        issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            p_q     <= RESET_PC;
            iss_q   <= 1'b0;
            pc_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            iss_q   <= iss_d;
            pc_q    <= pc_d;
        end
    end

`ifdef BTB_PREDICT_EN
    // BTB answers refer to the packet issued last cycle; a flush or reset makes them stale.
    always_comb begin
        hit         = ~rst & iss_q & ~bus.branch_flush & (|bus.btb_valid);
        taken       = 2'b00;
        target_pred = 32'h0;
        if (hit) begin
            if (bus.btb_valid[0]) begin
                taken       = 2'b01;
                target_pred = bus.pre_branch_addr[0];
            end else begin
                taken       = 2'b10;
                target_pred = bus.pre_branch_addr[1];
            end
        end
    end

    assign bus.pred_pc = hit ? pc_q : 32'h0;
`else
    logic unused_btb;

    assign hit         = 1'b0;
    assign taken       = 2'b00;
    assign target_pred = 32'h0;
    assign bus.pred_pc = 32'h0;
    assign unused_btb  = ^{iss_q, pc_q, bus.btb_valid, bus.pre_branch_addr[0], bus.pre_branch_addr[1]};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        inst_en = ~rst & (state_q == RUN) & ~bus.branch_flush & ~hit;
        issue   = inst_en & ~bus.stall;
        iss_d   = issue;
        pc_d    = issue ? p_q : pc_q;

        // A predicted redirect wins over stall: the stalled packet is thrown away anyway.
        p_d = p_q;
        if (bus.branch_flush) begin
            p_d = bus.branch_target;
        end else if (hit) begin
            p_d = target_pred;
        end else if (bus.stall || state_q == BOOT) begin
            p_d = p_q;
        end else begin
            p_d = p_q + 32'd8;
        end
    end

    assign bus.pc[0]       = rst ? RESET_PC : p_q;
    assign bus.pc[1]       = bus.pc[0] + 32'd4;
    assign bus.inst_en     = inst_en;
    assign bus.pred_taken  = taken;
    assign bus.pred_target = target_pred;
    assign bus.kill_slot1  = taken[0];

endmodule

// File: tb/tb_pc_gen_d.sv
// tb/tb_pc_gen_d.sv - scoreboard bench for pc_gen_d covering reset, hits, stall, flush, wrap
module tb_pc_gen_d;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_gen_d_if bus ();

    pc_gen_d #(.RESET_PC(32'h1C00_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic [1:0]  bv;
        logic [31:0] a0;
        logic [31:0] a1;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        en;
        logic [1:0]  pt;
        logic [31:0] ptgt;
        logic [31:0] ppc;
        logic        kill;
    } exp_t;

    stim_t stim_q[$];
    exp_t  sb[$];
    int    n_run  = 0;
    int    n_fail = 0;

`ifdef BTB_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    function automatic stim_t mk(logic r, logic st, logic fl, logic [31:0] tgt,
                                 logic [1:0] bv, logic [31:0] a0, logic [31:0] a1);
        stim_t s;
        s.rst = r; s.stall = st; s.flush = fl; s.tgt = tgt; s.bv = bv; s.a0 = a0; s.a1 = a1;
        return s;
    endfunction

    function automatic void push(stim_t s, logic [31:0] pc0, logic en, logic [1:0] pt,
                                 logic [31:0] ptgt, logic [31:0] ppc);
        exp_t e;
        e.pc0 = pc0; e.pc1 = pc0 + 32'd4; e.en = en; e.pt = pt;
        e.ptgt = ptgt; e.ppc = ppc; e.kill = pt[0];
        stim_q.push_back(s);
        sb.push_back(e);
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.pc0 = bus.pc[0]; o.pc1 = bus.pc[1]; o.en = bus.inst_en; o.pt = bus.pred_taken;
        o.ptgt = bus.pred_target; o.ppc = bus.pred_pc; o.kill = bus.kill_slot1;
        return o;
    endfunction

    task automatic apply(stim_t s);
        rst                    = s.rst;
        bus.stall              = s.stall;
        bus.branch_flush       = s.flush;
        bus.branch_target      = s.tgt;
        bus.btb_valid          = s.bv;
        bus.pre_branch_addr[0] = s.a0;
        bus.pre_branch_addr[1] = s.a1;
    endtask

    task automatic test_reset();
        stim_t st; exp_t got, ex; int row = 0;
        push(mk(1, 0, 0, 0, 2'b00, 0, 0), 32'h1C00_0000, 0, 2'b00, 0, 0);
        push(mk(1, 0, 0, 0, 2'b00, 0, 0), 32'h1C00_0000, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0), 32'h1C00_0000, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0), 32'h1C00_0000, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0), 32'h1C00_0008, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0), 32'h1C00_0010, 1, 2'b00, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front(); apply(st);
            @(negedge clk);
            got = observed(); ex = sb.pop_front(); n_run++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL reset row%0d: got pc0=%h pc1=%h en=%b pt=%b tgt=%h ppc=%h kill=%b; expected pc0=%h pc1=%h en=%b pt=%b tgt=%h ppc=%h kill=%b",
                         row, got.pc0, got.pc1, got.en, got.pt, got.ptgt, got.ppc, got.kill,
                         ex.pc0, ex.pc1, ex.en, ex.pt, ex.ptgt, ex.ppc, ex.kill);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_slot0_hit();
        stim_t st; exp_t got, ex; int row = 0;
        if (PRED) begin
            push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0100, 0), 32'h1C00_0018, 0, 2'b01, 32'h1C00_0100, 32'h1C00_0010);
            push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h1C00_0100, 1, 2'b00, 0, 0);
        end else begin
            push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0100, 0), 32'h1C00_0018, 1, 2'b00, 0, 0);
            push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h1C00_0020, 1, 2'b00, 0, 0);
        end
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front(); apply(st);
            @(negedge clk);
            got = observed(); ex = sb.pop_front(); n_run++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL slot0_hit row%0d: got pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b; expected pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b",
                         row, got.pc0, got.en, got.pt, got.ptgt, got.ppc, got.kill,
                         ex.pc0, ex.en, ex.pt, ex.ptgt, ex.ppc, ex.kill);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_slot1_stall_hit();
        stim_t st; exp_t got, ex; int row = 0;
        if (PRED) begin
            push(mk(0, 1, 0, 0, 2'b10, 0, 32'h1C00_0200), 32'h1C00_0108, 0, 2'b10, 32'h1C00_0200, 32'h1C00_0100);
            push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h1C00_0200, 1, 2'b00, 0, 0);
        end else begin
            push(mk(0, 1, 0, 0, 2'b10, 0, 32'h1C00_0200), 32'h1C00_0028, 1, 2'b00, 0, 0);
            push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h1C00_0028, 1, 2'b00, 0, 0);
        end
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front(); apply(st);
            @(negedge clk);
            got = observed(); ex = sb.pop_front(); n_run++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL slot1_stall_hit row%0d: got pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b; expected pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b",
                         row, got.pc0, got.en, got.pt, got.ptgt, got.ppc, got.kill,
                         ex.pc0, ex.en, ex.pt, ex.ptgt, ex.ppc, ex.kill);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_gap();
        stim_t st; exp_t got, ex; int row = 0;
        logic [31:0] cur = PRED ? 32'h1C00_0208 : 32'h1C00_0030;
        push(mk(0, 0, 1, 32'h1C00_0020, 2'b00, 0, 0), cur, 0, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++)
            push(mk(0, 1, 0, 0, 2'b01, 32'h1C00_0300, 0), 32'h1C00_0020, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0300, 0), 32'h1C00_0020, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h1C00_0028, 1, 2'b00, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front(); apply(st);
            @(negedge clk);
            got = observed(); ex = sb.pop_front(); n_run++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL stall_gap row%0d: got pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b; expected pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b",
                         row, got.pc0, got.en, got.pt, got.ptgt, got.ppc, got.kill,
                         ex.pc0, ex.en, ex.pt, ex.ptgt, ex.ppc, ex.kill);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_beats_hit();
        stim_t st; exp_t got, ex; int row = 0;
        push(mk(0, 0, 1, 32'h1C00_0400, 2'b01, 32'h1C00_0500, 0), 32'h1C00_0030, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0500, 0),             32'h1C00_0400, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),                         32'h1C00_0408, 1, 2'b00, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front(); apply(st);
            @(negedge clk);
            got = observed(); ex = sb.pop_front(); n_run++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL flush_beats_hit row%0d: got pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b; expected pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b",
                         row, got.pc0, got.en, got.pt, got.ptgt, got.ppc, got.kill,
                         ex.pc0, ex.en, ex.pt, ex.ptgt, ex.ppc, ex.kill);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        stim_t st; exp_t got, ex; int row = 0;
        push(mk(0, 0, 1, 32'hFFFF_FFF8, 2'b00, 0, 0), 32'h1C00_0410, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'hFFFF_FFF8, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h0000_0000, 1, 2'b00, 0, 0);
        push(mk(0, 0, 1, 32'hFFFF_FFFC, 2'b00, 0, 0), 32'h0000_0008, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'hFFFF_FFFC, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h0000_0004, 1, 2'b00, 0, 0);
        push(mk(0, 0, 1, 32'h1C00_0003, 2'b00, 0, 0), 32'h0000_000C, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h1C00_0003, 1, 2'b00, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front(); apply(st);
            @(negedge clk);
            got = observed(); ex = sb.pop_front(); n_run++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL wrap row%0d: got pc0=%h pc1=%h en=%b pt=%b; expected pc0=%h pc1=%h en=%b pt=%b",
                         row, got.pc0, got.pc1, got.en, got.pt, ex.pc0, ex.pc1, ex.en, ex.pt);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t st; exp_t got, ex; int row = 0;
        push(mk(1, 0, 0, 0, 2'b01, 32'h1C00_0600, 0), 32'h1C00_0000, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0600, 0), 32'h1C00_0000, 0, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0600, 0), 32'h1C00_0000, 1, 2'b00, 0, 0);
        push(mk(0, 0, 0, 0, 2'b00, 0, 0),             32'h1C00_0008, 1, 2'b00, 0, 0);
        if (PRED)
            push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0700, 0), 32'h1C00_0010, 0, 2'b01, 32'h1C00_0700, 32'h1C00_0008);
        else
            push(mk(0, 0, 0, 0, 2'b01, 32'h1C00_0700, 0), 32'h1C00_0010, 1, 2'b00, 0, 0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front(); apply(st);
            @(negedge clk);
            got = observed(); ex = sb.pop_front(); n_run++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL reset_mid row%0d: got pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b; expected pc0=%h en=%b pt=%b tgt=%h ppc=%h kill=%b",
                         row, got.pc0, got.en, got.pt, got.ptgt, got.ppc, got.kill,
                         ex.pc0, ex.en, ex.pt, ex.ptgt, ex.ppc, ex.kill);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0));
        @(posedge clk); #1;
        test_reset();
        test_slot0_hit();
        test_slot1_stall_hit();
        test_stall_gap();
        test_flush_beats_hit();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_d.md
PC_GEN_D -- requirements
Module: pc_gen_d

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C00_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  the fetch side cannot accept a packet this cycle.
REQ-005 SHALL have port branch_flush  input  1  backend redirect request.
REQ-006 SHALL have port branch_target  input  32  backend redirect address.
REQ-007 SHALL have port btb_valid  input  2  per-slot BTB hit, registered; refers to the pc presented in the previous cycle.
REQ-008 SHALL have port pre_branch_addr  input  2x32  per-slot BTB target, same timing as btb_valid.
REQ-009 SHALL have port pc  output  2x32  fetch packet addresses; slot 0 at pc[0], slot 1 at pc[1]; also drives the BTB lookup.
REQ-010 SHALL have port inst_en  output  1  the packet on pc is issued this cycle.
REQ-011 SHALL have port pred_taken  output  2  one-hot; the slot of the previously issued packet that is predicted taken.
REQ-012 SHALL have port pred_target  output  32  the predicted target, valid when pred_taken is non-zero.
REQ-013 SHALL have port pred_pc  output  32  pc[0] of the packet that pred_taken refers to.
REQ-014 SHALL have port kill_slot1  output  1  discard slot 1 of the previously issued packet.

Function
REQ-015 SHALL hold a 32-bit PC register P and drive pc[0]=P and pc[1]=P+4, both mod 2^32.
REQ-016 SHALL use a 2-state FSM: BOOT and RUN. BOOT is entered on rst and lasts exactly one cycle with inst_en=0. BOOT always goes to RUN. RUN stays in RUN until rst.
REQ-017 SHALL define issue: a packet is issued in cycle t iff state=RUN, inst_en=1 and stall=0 at t.
REQ-018 SHALL keep iss_q, which is 1 iff a packet was issued in the previous cycle and no flush occurred in that cycle. pc_q holds that packet's pc[0].
REQ-019 SHALL define a prediction hit as iss_q=1 and btb_valid!=0. Slot 0 has priority: btb_valid[0] gives pred_taken=2'b01 and target pre_branch_addr[0]; otherwise pred_taken=2'b10 and target pre_branch_addr[1].
REQ-020 SHALL drive pred_pc=pc_q on a hit. kill_slot1=pred_taken[0]. With no hit, pred_taken=0, kill_slot1=0 and pred_target=0.
REQ-021 SHALL ignore btb_valid whenever iss_q=0, including after a stall, after a flush and in BOOT.
REQ-022 SHALL compute inst_en = (state==RUN) & ~branch_flush & ~hit; this is a combinational path from the registered BTB outputs.
REQ-023 SHALL update P with priority rst > branch_flush > hit > stall > sequential:
- rst: P <= RESET_PC.
- branch_flush: P <= branch_target.
- hit: P <= pred_target; this applies even when stall=1.
- stall, or state=BOOT: P holds.
- otherwise: P <= P+8.
REQ-024 SHALL suppress any hit in the same cycle as branch_flush. pred_taken=0 and kill_slot1=0 in that cycle.
REQ-025 SHALL wrap addresses: P=32'hFFFF_FFF8 gives a next P of 0, and P=32'hFFFF_FFFC gives pc[1]=0.
REQ-026 SHALL impose no alignment on branch_target or pred_target beyond taking the value as given.

Reset
REQ-027 SHALL, while rst=1, set state=BOOT, P=RESET_PC, iss_q=0 and pc_q=0.
REQ-028 SHALL, while rst=1, drive outputs pc={RESET_PC+4, RESET_PC}, inst_en=0, pred_taken=0, pred_target=0, pred_pc=0 and kill_slot1=0.
REQ-029 SHALL, when rst is asserted mid-operation, discard pending iss_q and any hit in that cycle.

Configuration
REQ-030 SHALL, with macro BTB_PREDICT_EN defined, implement REQ-019..REQ-024 as written.
REQ-031 SHALL, without BTB_PREDICT_EN:
- ignore btb_valid and pre_branch_addr;
- tie pred_taken, pred_target, pred_pc and kill_slot1 to 0;
- fetch sequentially and redirect only on branch_flush.

Verification
REQ-032 SHALL cover reset: rst for 2 cycles, then release -> one BOOT cycle with inst_en=0 and pc[0]=1C000000, then pc[0] = 1C000000, 1C000008, 1C000010 with inst_en=1.
REQ-033 SHALL cover a slot-0 hit: issue at 1C000010; next cycle btb_valid=01 and pre_branch_addr[0]=1C000100 -> that cycle pred_taken=01, kill_slot1=1, pred_pc=1C000010, inst_en=0; next pc[0]=1C000100.
REQ-034 SHALL cover a slot-1 hit with stall: btb_valid=10, pre_branch_addr[1]=1C000200 and stall=1 in the hit cycle -> pred_taken=10, kill_slot1=0; next pc[0]=1C000200.
REQ-035 SHALL cover a stall gap: stall=1 for 3 cycles at pc[0]=1C000020 with btb_valid=01 held -> no pred_taken after the first post-stall cycle; P holds; resumes at 1C000028 after stall drops.
REQ-036 SHALL cover flush beating a hit: branch_flush=1 with branch_target=1C000400 in the same cycle as btb_valid=01 -> pred_taken=0, inst_en=0; next pc[0]=1C000400; the following cycle ignores btb_valid.
REQ-037 SHALL cover wrap: flush to FFFFFFF8 -> pc={FFFFFFFC, FFFFFFF8}, then pc[0]=00000000.
